// File: rtl/ifu_fetch_pkg.sv
// Shared core package: AXI widths, the NOP encoding and the fetch FSM states.
`include "ifu_fetch_defines.sv"

package ifu_fetch_pkg;

    localparam int AXI_ADDR_W = `IFU_AXI_ADDR_W;
    localparam int AXI_DATA_W = `IFU_AXI_DATA_W;
    localparam int AXI_STRB_W = `IFU_AXI_STRB_W;
    localparam int AXI_RESP_W = `IFU_AXI_RESP_W;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY = 2'b00;

    // addi x0, x0, 0 -- what decode sees whenever no real instruction exists
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ADDR    = 2'd0,
        DATA    = 2'd1,
        OUT     = 2'd2,
        WAIT_PC = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// AXI-lite port bundle between the fetch unit and the instruction SRAM.
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    logic [AXI_ADDR_W-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [AXI_RESP_W-1:0] rresp;
    logic                  rvalid;
    logic                  rready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wvalid;
    logic                  bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/ifu_fetch_defines.sv
// Common AXI-lite width macros shared by the fetch unit files.
`ifndef IFU_FETCH_DEFINES_SV
`define IFU_FETCH_DEFINES_SV

`define IFU_AXI_ADDR_W 32
`define IFU_AXI_DATA_W 32
`define IFU_AXI_STRB_W 4
`define IFU_AXI_RESP_W 2

`endif

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one AXI-lite read per instruction, handed to decode,
// then waits for writeback to supply the next PC.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] INST_NOP = ifu_fetch_pkg::INST_NOP
) (
    input  logic               clk,
    input  logic               rst,
    ifu_fetch_if.master        axi,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic               inst_fault,
    output logic               inst_valid,
    input  logic               inst_ready,
    input  logic [31:0]        npc,
    input  logic               npc_valid,
    output logic               npc_ready
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic         misaligned;
    logic         arvalid;
    logic         rready;
    logic         load_data;
    logic         load_misalign;
    logic         load_npc;

    assign misaligned = (pc[1:0] != 2'b00);

    assign axi.araddr  = pc;
    assign axi.arvalid = arvalid;
    assign axi.rready  = rready;
    assign axi.awaddr  = '0;
    assign axi.awvalid = 1'b0;
    assign axi.wdata   = '0;
    assign axi.wstrb   = '0;
    assign axi.wvalid  = 1'b0;
    assign axi.bready  = 1'b1;

    // Outputs are gated by rst so nothing is offered to the SRAM or decode while reset is held.
    always_comb begin
        state_next    = state;
        arvalid       = 1'b0;
        rready        = 1'b0;
        inst_valid    = 1'b0;
        npc_ready     = 1'b0;
        load_data     = 1'b0;
        load_misalign = 1'b0;
        load_npc      = 1'b0;
        if (!rst) begin
            case (state)
                ADDR: begin
                    if (misaligned) begin
                        load_misalign = 1'b1;
                        state_next    = OUT;
                    end else begin
                        arvalid = 1'b1;
                        if (axi.arready) begin
                            state_next = DATA;
                        end
                    end
                end
                DATA: begin
                    rready = 1'b1;
                    if (axi.rvalid) begin
                        load_data  = 1'b1;
                        state_next = OUT;
                    end
                end
                OUT: begin
                    inst_valid = 1'b1;
                    if (inst_ready) begin
                        state_next = WAIT_PC;
                    end
                end
                WAIT_PC: begin
                    npc_ready = 1'b1;
                    if (npc_valid) begin
                        load_npc   = 1'b1;
                        state_next = ADDR;
                    end
                end
                default: state_next = ADDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ADDR;
            pc         <= RESET_PC;
            inst       <= INST_NOP;
            inst_pc    <= RESET_PC;
            inst_fault <= 1'b0;
        end else begin
            state <= state_next;
            if (load_data) begin
                inst       <= axi.rdata;
                inst_pc    <= pc;
                inst_fault <= (axi.rresp != RESP_OKAY);
            end else if (load_misalign) begin
                inst       <= INST_NOP;
                inst_pc    <= pc;
                inst_fault <= 1'b1;
            end
            if (load_npc) begin
                pc <= npc;
            end
        end
    end

endmodule
